// File: rtl/pwm_ton_timer_mc.sv
// Multi-channel programmable on-time limiter: each channel times a latched on-time
// from a set edge and emits a one-cycle reset_pwm pulse, with retrigger, holdoff and abort.
module pwm_ton_timer_mc #(
    parameter int CH       = 4,
    parameter int CNT_W    = 16,
    parameter int HOLD_CYC = 8,
    parameter int HOLD_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  retrig,
    input  logic [CH-1:0]         set,
    input  logic [CH-1:0]         abort,
    input  logic [CH*CNT_W-1:0]   ton_cfg,
    input  logic [CH-1:0]         miss_clr,
    output logic [CH-1:0]         reset_pwm,
    output logic [CH-1:0]         busy,
    output logic [CH-1:0]         miss
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_t;

    localparam logic              HOLD_EN   = 1'(HOLD_CYC > 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    logic [CH-1:0] set_d;
    logic [CH-1:0] set_pos;
    logic [CH-1:0] expire;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_d <= '0;
        end else begin
            set_d <= set;
        end
    end

    assign set_pos = set & ~set_d;

    // The expiry flag is registered; abort and en gate it in the pulse cycle itself
    // so that either one wins over an expiry landing in the same cycle.
    assign reset_pwm = expire & ~abort & {CH{en}};

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t             state_q;
        logic [CNT_W-1:0]   cnt_q;
        logic [CNT_W-1:0]   ton_q;
        logic [CNT_W-1:0]   ton_new;
        logic [CNT_W-1:0]   cnt_nxt;
        logic [HOLD_W-1:0]  hold_q;
        logic               expire_q;
        logic               busy_q;
        logic               miss_q;
        logic               start;
        logic               drop;

        assign ton_new = (ton_cfg[i*CNT_W +: CNT_W] == '0) ? CNT_W'(1)
                                                           : ton_cfg[i*CNT_W +: CNT_W];
        assign cnt_nxt = cnt_q + CNT_W'(1);

        // An edge that coincides with expiry under retrigger counts as a holdoff edge.
        assign start = en && !abort[i] && set_pos[i] &&
                       ((state_q == ST_IDLE) ||
                        (state_q == ST_RUN && retrig && (!expire_q || !HOLD_EN)));
        assign drop  = en && !abort[i] && set_pos[i] &&
                       ((state_q == ST_HOLD) ||
                        (state_q == ST_RUN && expire_q && retrig && HOLD_EN));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                ton_q    <= '0;
                hold_q   <= '0;
                expire_q <= 1'b0;
                busy_q   <= 1'b0;
                miss_q   <= 1'b0;
            end else begin
                miss_q <= (miss_q & ~miss_clr[i]) | drop;

                if (!en || abort[i]) begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= '0;
                    hold_q   <= '0;
                    expire_q <= 1'b0;
                    busy_q   <= 1'b0;
                end else if (start) begin
                    state_q  <= ST_RUN;
                    ton_q    <= ton_new;
                    cnt_q    <= CNT_W'(1);
                    expire_q <= (ton_new == CNT_W'(1));
                    busy_q   <= 1'b1;
                end else begin
                    case (state_q)
                        ST_RUN: begin
                            if (expire_q) begin
                                state_q  <= HOLD_EN ? ST_HOLD : ST_IDLE;
                                hold_q   <= HOLD_LAST;
                                cnt_q    <= '0;
                                expire_q <= 1'b0;
                                busy_q   <= 1'b0;
                            end else begin
                                cnt_q    <= cnt_nxt;
                                expire_q <= (cnt_nxt == ton_q);
                            end
                        end
                        ST_HOLD: begin
                            if (hold_q == '0) begin
                                state_q <= ST_IDLE;
                            end else begin
                                hold_q <= hold_q - HOLD_W'(1);
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                        end
                    endcase
                end
            end
        end

        assign expire[i] = expire_q;
        assign busy[i]   = busy_q;
        assign miss[i]   = miss_q;
    end

endmodule

// File: tb/tb_pwm_ton_timer_mc.sv
// Directed bench for pwm_ton_timer_mc: per-cycle stimulus tables, logged outputs,
// hand-computed pulse/busy/miss expectations.
module tb_pwm_ton_timer_mc;

    localparam int CH    = 4;
    localparam int CNT_W = 16;
    localparam int LOG_N = 128;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic                retrig;
    logic [CH-1:0]       set;
    logic [CH-1:0]       abort;
    logic [CH*CNT_W-1:0] ton_cfg;
    logic [CH-1:0]       miss_clr;
    logic [CH-1:0]       reset_pwm;
    logic [CH-1:0]       busy;
    logic [CH-1:0]       miss;

    int n_checks;
    int n_fail;

    logic [CH-1:0] set_s   [LOG_N];
    logic [CH-1:0] abort_s [LOG_N];
    logic [CH-1:0] clr_s   [LOG_N];
    logic          en_s    [LOG_N];
    logic [CH-1:0] pwm_log  [LOG_N];
    logic [CH-1:0] busy_log [LOG_N];
    logic [CH-1:0] miss_log [LOG_N];

    pwm_ton_timer_mc #(
        .CH(CH), .CNT_W(CNT_W), .HOLD_CYC(8), .HOLD_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .retrig(retrig), .set(set),
        .abort(abort), .ton_cfg(ton_cfg), .miss_clr(miss_clr),
        .reset_pwm(reset_pwm), .busy(busy), .miss(miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_sched();
        for (int t = 0; t < LOG_N; t++) begin
            set_s[t]   = '0;
            abort_s[t] = '0;
            clr_s[t]   = '0;
            en_s[t]    = 1'b1;
        end
    endtask

    // Cycle t spans posedge t .. posedge t+1; inputs applied just after the edge,
    // outputs logged at the falling edge.
    task automatic run(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk); #1;
            set      = set_s[t];
            abort    = abort_s[t];
            miss_clr = clr_s[t];
            en       = en_s[t];
            @(negedge clk);
            pwm_log[t]  = reset_pwm;
            busy_log[t] = busy;
            miss_log[t] = miss;
        end
        @(posedge clk); #1;
        set = '0; abort = '0; miss_clr = '0; en = 1'b1;
    endtask

    function automatic int npulse(input int ch, input int lo, input int hi);
        int c = 0;
        for (int t = lo; t <= hi; t++) if (pwm_log[t][ch]) c++;
        return c;
    endfunction

    function automatic int nquiet_others(input int lo, input int hi);
        int c = 0;
        for (int t = lo; t <= hi; t++) if ((pwm_log[t][3:1] | busy_log[t][3:1]) != 3'b000) c++;
        return c;
    endfunction

    initial begin
        int first;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; en = 1'b1; retrig = 1'b0; set = '0; abort = '0; miss_clr = '0;
        ton_cfg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pwm_rst", 32'(reset_pwm), 0);
        check("busy_rst", 32'(busy), 0);
        check("miss_rst", 32'(miss), 0);
        rst_n = 1'b1;

        // Basic one-shot
        ton_cfg[0 +: CNT_W] = 16'd40;
        clear_sched(); set_s[10] = 4'b0001;
        run(70);
        check("basic_npulse", npulse(0, 0, 69), 1);
        check("basic_pulse50", 32'(pwm_log[50][0]), 1);
        check("basic_busy10", 32'(busy_log[10][0]), 0);
        check("basic_busy11", 32'(busy_log[11][0]), 1);
        check("basic_busy50", 32'(busy_log[50][0]), 1);
        check("basic_busy51", 32'(busy_log[51][0]), 0);
        check("basic_others", nquiet_others(0, 69), 0);

        // Retrigger on
        retrig = 1'b1; ton_cfg[0 +: CNT_W] = 16'd20;
        clear_sched(); set_s[0] = 4'b0001; set_s[12] = 4'b0001;
        run(50);
        check("retrig_npulse", npulse(0, 0, 49), 1);
        check("retrig_pulse32", 32'(pwm_log[32][0]), 1);
        check("retrig_nopulse20", 32'(pwm_log[20][0]), 0);
        check("retrig_miss", 32'(miss_log[49][0]), 0);

        // Retrigger off
        retrig = 1'b0;
        run(50);
        check("oneshot_npulse", npulse(0, 0, 49), 1);
        check("oneshot_pulse20", 32'(pwm_log[20][0]), 1);
        check("oneshot_miss", 32'(miss_log[49][0]), 0);

        // Holdoff drop, miss set/clear, set+clear same cycle
        ton_cfg[0 +: CNT_W] = 16'd5;
        clear_sched();
        set_s[0] = 4'b0001; set_s[9] = 4'b0001; set_s[15] = 4'b0001; set_s[24] = 4'b0001;
        clr_s[20] = 4'b0001; clr_s[24] = 4'b0001; clr_s[30] = 4'b0001;
        run(45);
        check("hold_pulse5", 32'(pwm_log[5][0]), 1);
        check("hold_npulse", npulse(0, 0, 44), 2);
        check("hold_miss9", 32'(miss_log[9][0]), 0);
        check("hold_miss10", 32'(miss_log[10][0]), 1);
        check("hold_busy16", 32'(busy_log[16][0]), 1);
        check("hold_pulse20", 32'(pwm_log[20][0]), 1);
        check("hold_miss21", 32'(miss_log[21][0]), 0);
        check("hold_setclr25", 32'(miss_log[25][0]), 1);
        check("hold_miss31", 32'(miss_log[31][0]), 0);

        // Abort beats expiry; abort beats set_pos
        ton_cfg[0 +: CNT_W] = 16'd10;
        clear_sched();
        set_s[0] = 4'b0001; abort_s[10] = 4'b0001;
        set_s[12] = 4'b0001;
        set_s[40] = 4'b0001; abort_s[40] = 4'b0001;
        run(65);
        check("abort_nopulse10", 32'(pwm_log[10][0]), 0);
        check("abort_busy11", 32'(busy_log[11][0]), 0);
        check("abort_idle_restart", 32'(pwm_log[22][0]), 1);
        check("abort_npulse", npulse(0, 0, 64), 1);
        check("abort_nostart", 32'(busy_log[41][0]), 0);

        // ton_cfg = 0 behaves as 1
        ton_cfg[0 +: CNT_W] = 16'd0;
        clear_sched(); set_s[0] = 4'b0001;
        run(20);
        check("ton0_pulse1", 32'(pwm_log[1][0]), 1);
        check("ton0_busy1", 32'(busy_log[1][0]), 1);
        check("ton0_busy2", 32'(busy_log[2][0]), 0);
        check("ton0_npulse", npulse(0, 0, 19), 1);

        // en dropped mid-RUN
        ton_cfg[0 +: CNT_W] = 16'd10;
        clear_sched(); set_s[0] = 4'b0001; en_s[5] = 1'b0;
        run(30);
        check("en_busy5", 32'(busy_log[5][0]), 1);
        check("en_busy6", 32'(busy_log[6][0]), 0);
        check("en_npulse", npulse(0, 0, 29), 0);

        // Full-scale on-time: pulse 65535 cycles after the edge
        ton_cfg[0 +: CNT_W] = 16'hFFFF;
        set = 4'b0001;
        @(posedge clk); #1;
        set = '0;
        first = -1;
        for (int t = 1; t < 70000; t++) begin
            @(negedge clk);
            if (reset_pwm[0]) begin
                first = t;
                break;
            end
            @(posedge clk); #1;
        end
        check("tonmax_pulse", first, 65535);
        clear_sched();
        run(15);

        // set held high through reset release -> one start
        ton_cfg[0 +: CNT_W] = 16'd3;
        @(posedge clk); #1;
        rst_n = 1'b0; set = 4'b0001;
        @(negedge clk);
        rst_n = 1'b1;
        clear_sched();
        for (int t = 0; t < 30; t++) set_s[t] = 4'b0001;
        run(30);
        check("rstset_busy0", 32'(busy_log[0][0]), 1);
        check("rstset_npulse", npulse(0, 0, 29), 1);

        // Four channels, reset mid-operation
        ton_cfg = {16'd15, 16'd11, 16'd7, 16'd3};
        clear_sched(); set_s[0] = 4'b1111;
        run(9);
        check("mc_busy2", 32'(busy_log[2]), 32'hF);
        check("mc_pulse3", 32'(pwm_log[3]), 32'h1);
        check("mc_pulse7", 32'(pwm_log[7]), 32'h2);
        check("mc_busy8", 32'(busy_log[8]), 32'hC);
        rst_n = 1'b0;
        #1;
        check("mc_rst_busy", 32'(busy), 0);
        check("mc_rst_pwm", 32'(reset_pwm), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_sched();
        run(20);
        first = 0;
        for (int t = 0; t < 20; t++) if ((pwm_log[t] | busy_log[t]) != '0) first++;
        check("mc_suppressed", first, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
